// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP accumulate sequencer family.
package fp_pkg;

    localparam int          FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_TWO  = 32'h4000_0000;

    // Cycles after a start pulse during which the adder's done still reflects
    // the previous operation and must not be trusted.
    localparam int ADD_DONE_BLANK = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        NEXT  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        OUT   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/fpadd_accum_seq_if.sv
// Bundle of the operand stream, adder control and result stream.
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; the producer holds data stable while valid && !ready, and the
// consumer may raise or lower ready freely.
interface fpadd_accum_seq_if import fp_pkg::*; #(
    parameter int CNT_W = 16
) ();
    // operand stream into the sequencer
    logic [FP_W-1:0]  in_data;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    // adder control / result
    logic             add_start;
    logic [FP_W-1:0]  add_a;
    logic [FP_W-1:0]  add_b;
    logic [FP_W-1:0]  add_sum;
    logic             add_done;
    // packet result stream
    logic [FP_W-1:0]  out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;
    logic             out_valid;
    logic             out_ready;

    // Sequencer side
    modport master (
        input  in_data, in_last, in_valid, add_sum, add_done, out_ready,
        output in_ready, add_start, add_a, add_b,
        output out_data, out_count, out_err, out_valid
    );

    // Environment side: operand source, adder and result sink
    modport slave (
        output in_data, in_last, in_valid, add_sum, add_done, out_ready,
        input  in_ready, add_start, add_a, add_b,
        input  out_data, out_count, out_err, out_valid
    );
endinterface

// File: rtl/fp_op_watchdog.sv
// Cycle watchdog for a multi-cycle FP operation: counts enabled cycles since
// clear and flags the last allowed cycle.
module fp_op_watchdog #(
    parameter int WATCHDOG_CYCLES = 64,
    parameter int WD_W            = $clog2(WATCHDOG_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            enable_i,
    output logic [WD_W-1:0] elapsed_o,
    output logic            expired_o
);
    localparam logic [WD_W-1:0] LIMIT = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] cnt_q, cnt_d;

    // Count enabled cycles, saturating on the last allowed one.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign elapsed_o = cnt_q;
    // High during the WATCHDOG_CYCLES-th enabled cycle after clear.
    assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/fpadd_accum_seq.sv
// Packet accumulator sequencer: feeds a stream of FP32 operands through an
// external multi-cycle adder, keeping the running sum, and emits the packet
// total with its element count and a watchdog error flag.
module fpadd_accum_seq import fp_pkg::*; #(
    parameter int CNT_W           = 16,
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    fpadd_accum_seq_if.master   bus,
    output seq_state_t          dbg_state_o
);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    seq_state_t       state_q, state_d;
    logic [FP_W-1:0]  acc_q, acc_d;
    logic [FP_W-1:0]  a_q, a_d;
    logic [FP_W-1:0]  b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             last_q, last_d;

    logic             wd_clear;
    logic             wd_enable;
    logic [WD_W-1:0]  wd_elapsed;
    logic             wd_expired;
    logic             done_open;

    fp_op_watchdog #(
        .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
        .WD_W            (WD_W)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .elapsed_o (wd_elapsed),
        .expired_o (wd_expired)
    );

    // The adder's done is only believed once its start has been registered.
    assign done_open = (wd_elapsed >= WD_W'(ADD_DONE_BLANK));

    // Next-state and datapath selection.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        last_d    = last_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FIRST;
            end
            FIRST: begin
                if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    cnt_d   = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = bus.in_last ? OUT : NEXT;
                end
            end
            NEXT: begin
                if (bus.in_valid) begin
                    a_d     = acc_q;
                    b_d     = bus.in_data;
                    last_d  = bus.in_last;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_clear = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_enable = 1'b1;
                if (bus.add_done && done_open) begin
                    acc_d   = bus.add_sum;
                    state_d = last_q ? OUT : NEXT;
                end else if (wd_expired) begin
                    // Adder is stuck: report the partial sum and drop the op.
                    err_d   = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    state_d = FIRST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= FP_ZERO;
            a_q     <= FP_ZERO;
            b_q     <= FP_ZERO;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    assign bus.in_ready  = (state_q == FIRST) || (state_q == NEXT);
    assign bus.add_start = (state_q == ISSUE);
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_err   = err_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fpadd_accum_seq.sv
// Directed bench for fpadd_accum_seq with a behavioural multi-cycle adder.
module tb_fpadd_accum_seq;
    import fp_pkg::*;

    localparam logic [31:0] FP_THREE = 32'h4040_0000;
    localparam logic [31:0] FP_FOUR  = 32'h4080_0000;
    localparam logic [31:0] FP_SIX   = 32'h40C0_0000;

    logic       clk;
    logic       reset;
    logic       mdl_rst;
    seq_state_t dbg_state;

    int checks   = 0;
    int failures = 0;

    // expected {err, count[15:0], data[31:0]}
    logic [48:0] exp_q[$];

    // adder model controls
    int   mdl_latency = 10;
    int   mdl_stale   = 0;
    logic mdl_hang    = 1'b0;
    int   start_pulses = 0;

    logic [31:0] pend_sum;
    int          lat_cnt;
    int          stale_cnt;
    logic        busy;

    fpadd_accum_seq_if bus ();

    fpadd_accum_seq dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sum table for the operand pairs the bench uses.
    function automatic logic [31:0] fp_add_lut(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] key;
        key = {a, b};
        case (key)
            {FP_ONE, FP_TWO}:     return FP_THREE;
            {FP_THREE, FP_THREE}: return FP_SIX;
            {FP_ONE, FP_ONE}:     return FP_TWO;
            {FP_TWO, FP_TWO}:     return FP_FOUR;
            default:              return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Adder model: done clears on start (or mdl_stale cycles later), rises
    // mdl_latency cycles after start unless hung. Not reset by the DUT reset.
    always @(posedge clk) begin
        if (mdl_rst) begin
            bus.add_done <= 1'b0;
            bus.add_sum  <= 32'h0;
            busy         <= 1'b0;
            lat_cnt      <= 0;
            stale_cnt    <= 0;
            pend_sum     <= 32'h0;
        end else if (bus.add_start) begin
            pend_sum  <= fp_add_lut(bus.add_a, bus.add_b);
            lat_cnt   <= mdl_latency;
            busy      <= 1'b1;
            stale_cnt <= mdl_stale;
            if (mdl_stale == 0) bus.add_done <= 1'b0;
        end else begin
            if (stale_cnt > 0) begin
                stale_cnt <= stale_cnt - 1;
                if (stale_cnt == 1) bus.add_done <= 1'b0;
            end
            if (busy) begin
                if (lat_cnt <= 1) begin
                    busy <= 1'b0;
                    if (!mdl_hang) begin
                        bus.add_done <= 1'b1;
                        bus.add_sum  <= pend_sum;
                    end
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bus.add_start) start_pulses <= start_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand and hold it until accepted.
    task automatic send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        check("send_accept", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until out_valid is seen on a falling edge.
    task automatic wait_out(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.out_valid && waited < budget);
        check("out_valid_seen", {63'd0, bus.out_valid}, 64'd1);
    endtask

    // Compare the presented result against the scoreboard, then accept it.
    task automatic pop_accept(input string tag);
        logic [48:0] exp;
        exp = 49'h1_FFFF_FFFF_FFFF;
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        check(tag, {15'd0, bus.out_err, bus.out_count, bus.out_data}, {15'd0, exp});
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("rst_add_start", {63'd0, bus.add_start}, 64'd0);
        check("rst_add_a",     {32'd0, bus.add_a},     64'd0);
        check("rst_add_b",     {32'd0, bus.add_b},     64'd0);
        check("rst_out_data",  {32'd0, bus.out_data},  64'd0);
        check("rst_out_count", {48'd0, bus.out_count}, 64'd0);
        check("rst_out_err",   {63'd0, bus.out_err},   64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_state",     {61'd0, dbg_state},     {61'd0, IDLE});
    endtask

    initial begin
        int          w;
        int          s0;
        logic [48:0] snap;

        // reset
        reset         = 1'b1;
        mdl_rst       = 1'b1;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset   = 1'b0;
        mdl_rst = 1'b0;

        // single-element packet: no add issued
        s0 = start_pulses;
        exp_q.push_back({1'b0, 16'd1, FP_ONE});
        send(FP_ONE, 1'b1);
        wait_out(50, w);
        pop_accept("single_result");
        check("single_starts", 64'(start_pulses - s0), 64'd0);

        // 1.0 + 2.0 + 3.0 with a 10-cycle adder
        mdl_latency = 10;
        s0 = start_pulses;
        exp_q.push_back({1'b0, 16'd3, FP_SIX});
        send(FP_ONE, 1'b0);
        send(FP_TWO, 1'b0);
        send(FP_THREE, 1'b1);
        wait_out(200, w);
        pop_accept("three_result");
        check("three_starts", 64'(start_pulses - s0), 64'd2);

        // stale done (previous sum 6.0) held after start must be ignored
        mdl_stale = 2;
        exp_q.push_back({1'b0, 16'd2, FP_TWO});
        send(FP_ONE, 1'b0);
        send(FP_ONE, 1'b1);
        wait_out(200, w);
        pop_accept("stale_result");
        mdl_stale = 0;

        // output backpressure with a waiting input element
        exp_q.push_back({1'b0, 16'd1, FP_TWO});
        send(FP_TWO, 1'b1);
        wait_out(50, w);
        snap = {bus.out_err, bus.out_count, bus.out_data};
        bus.in_data  = FP_ONE;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_data", {15'd0, bus.out_err, bus.out_count, bus.out_data}, {15'd0, snap});
            check("bp_in_ready",  {63'd0, bus.in_ready}, 64'd0);
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        pop_accept("bp_result");
        @(negedge clk);
        check("bp_first_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_q.push_back({1'b0, 16'd1, FP_ONE});
        wait_out(50, w);
        pop_accept("bp_next_result");

        // hung adder: watchdog reports the first element with err
        mdl_hang = 1'b1;
        exp_q.push_back({1'b1, 16'd2, FP_ONE});
        send(FP_ONE, 1'b0);
        send(FP_TWO, 1'b1);
        wait_out(200, w);
        check("wd_latency", 64'(w), 64'd66);
        pop_accept("wd_result");
        mdl_hang = 1'b0;
        exp_q.push_back({1'b0, 16'd2, FP_TWO});
        send(FP_ONE, 1'b0);
        send(FP_ONE, 1'b1);
        wait_out(200, w);
        pop_accept("wd_recover_result");

        // reset while waiting on the adder
        send(FP_ONE, 1'b0);
        send(FP_ONE, 1'b1);
        repeat (3) @(negedge clk);
        check("pre_rst_state", {61'd0, dbg_state}, {61'd0, WAIT});
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        s0 = start_pulses;
        exp_q.push_back({1'b0, 16'd2, FP_FOUR});
        send(FP_TWO, 1'b0);
        send(FP_TWO, 1'b1);
        wait_out(200, w);
        pop_accept("post_rst_result");
        check("post_rst_starts", 64'(start_pulses - s0), 64'd1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
